// File: rtl/riscv_if_parcel_queue.sv
// riscv_if_parcel_queue: buffers fetch parcels and slices them into instructions for decode
// Ports: clk/rst (async, active-high); if_parcel_valid/if_parcel/if_parcel_pc/if_parcel_misaligned
// from fetch, if_stall back-pressure, if_flush; id_stall from decode; id_valid/id_instr/id_pc/
// id_misaligned/id_is_rvc to decode. Define RVC_EN to slice 16-bit compressed instructions.
module riscv_if_parcel_queue #(
  parameter int XLEN        = 64,
  parameter int PARCEL_SIZE = 64,
  parameter int DEPTH       = 4,
  parameter int ILEN        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_parcel_valid,
  input  logic [PARCEL_SIZE-1:0] if_parcel,
  input  logic [XLEN-1:0]        if_parcel_pc,
  input  logic                   if_parcel_misaligned,
  output logic                   if_stall,
  input  logic                   if_flush,
  input  logic                   id_stall,
  output logic                   id_valid,
  output logic [ILEN-1:0]        id_instr,
  output logic [XLEN-1:0]        id_pc,
  output logic                   id_misaligned,
  output logic                   id_is_rvc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef RVC_EN
  localparam int US = 16;
  localparam int LB = 1;
`else
  localparam int US = 32;
  localparam int LB = 2;
`endif
  localparam int NU = PARCEL_SIZE / US;
  localparam int OW = (NU > 1) ? $clog2(NU) : 1;
  localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0013);
  logic [PARCEL_SIZE-1:0] par_q [DEPTH];
  logic [XLEN-1:0]        pc_q  [DEPTH];
  logic                   mis_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] off_q, off_d, adv, off_ld;
  logic [PARCEL_SIZE-1:0] hp;
  logic [US-1:0] lo;
  logic [ILEN-1:0] instr;
  logic hmis, nonempty, at_end, complete, last, straddle, rvc, consume, pop, push, mis_in;
`ifdef RVC_EN
  logic is16;
  logic [15:0] hi;
`endif
  always_comb begin
    hp       = par_q[rd_q];
    hmis     = mis_q[rd_q];
    nonempty = cnt_q != '0;
    lo       = hp[off_q*US +: US];
    at_end   = off_q == OW'(NU-1);
`ifdef RVC_EN
    is16     = lo[1:0] != 2'b11;
    hi       = at_end ? par_q[rd_q + PW'(1)][15:0] : hp[OW'(off_q + 1'b1)*16 +: 16];
    // a 32-bit instruction in the last halfword needs the next entry's first halfword
    straddle = ~is16 & at_end;
    complete = hmis | ~straddle | (cnt_q >= CW'(2));
    last     = hmis | at_end | (~is16 & (off_q == OW'(NU-2)));
    adv      = is16 ? OW'(1) : OW'(2);
    instr    = hmis ? NOP : is16 ? ILEN'(lo) : ILEN'({hi, lo});
    rvc      = ~hmis & is16;
    mis_in   = if_parcel_misaligned | if_parcel_pc[0];
`else
    straddle = 1'b0;
    complete = 1'b1;
    last     = hmis | at_end;
    adv      = OW'(1);
    instr    = hmis ? NOP : ILEN'(lo);
    rvc      = 1'b0;
    mis_in   = if_parcel_misaligned | (|if_parcel_pc[1:0]);
`endif
    id_valid      = nonempty & ~if_flush & complete;
    id_instr      = nonempty ? instr : NOP;
    id_pc         = ~nonempty ? '0 : hmis ? pc_q[rd_q] :
                    (pc_q[rd_q] & ~XLEN'(PARCEL_SIZE/8 - 1)) | (XLEN'(off_q) << LB);
    id_misaligned = id_valid & hmis;
    id_is_rvc     = id_valid & rvc;
    if_stall      = cnt_q >= CW'(DEPTH-1);
    consume       = id_valid & ~id_stall;
    pop           = consume & last;
    push          = if_parcel_valid & ~if_flush & (cnt_q < CW'(DEPTH));
    off_ld        = OW'((if_parcel_pc >> LB) & XLEN'(NU-1));
    cnt_d         = if_flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    rd_d          = if_flush ? '0 : rd_q + PW'(pop);
    wr_d          = if_flush ? '0 : wr_q + PW'(push);
    // the pushed parcel becomes the head when the queue is (or is just becoming) empty
    off_d         = if_flush ? '0 :
                    (push & ((cnt_q == '0) | ((cnt_q == CW'(1)) & pop))) ? off_ld :
                    pop ? OW'(straddle) : consume ? off_q + adv : off_q;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      par_q[wr_q] <= if_parcel;
      pc_q[wr_q]  <= if_parcel_pc;
      mis_q[wr_q] <= mis_in;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      off_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      off_q <= off_d;
    end
  end
endmodule

// File: tb/tb_riscv_if_parcel_queue.sv
// tb_riscv_if_parcel_queue: directed and randomized checks of the parcel queue
module tb_riscv_if_parcel_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b1;
  logic if_parcel_valid = 1'b0, if_parcel_misaligned = 1'b0, if_flush = 1'b0, id_stall = 1'b0;
  logic [63:0] if_parcel = '0, if_parcel_pc = '0;
  logic if_stall, id_valid, id_misaligned, id_is_rvc;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  riscv_if_parcel_queue dut (
    .clk(clk), .rst(rst), .if_parcel_valid(if_parcel_valid), .if_parcel(if_parcel),
    .if_parcel_pc(if_parcel_pc), .if_parcel_misaligned(if_parcel_misaligned), .if_stall(if_stall),
    .if_flush(if_flush), .id_stall(id_stall), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_misaligned(id_misaligned), .id_is_rvc(id_is_rvc)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        mis;
    logic        rvc;
    logic        last;
  } item_t;
  item_t mq[$];
  item_t got[$];
  item_t e_it;
  int nent;
  int n_cmp = 0, n_bad = 0;
  logic e_valid, e_stall, o_valid, o_stall, o_mis, o_rvc;
  logic [31:0] o_instr;
  logic [63:0] o_pc;
  function automatic logic ent_mis(input logic [63:0] pc, input logic m);
`ifdef RVC_EN
    return m | pc[0];
`else
    return m | (pc[1:0] != 2'b00);
`endif
  endfunction
  // reference: a parcel expands into the list of items decode will see
  function automatic void model_push(input logic [63:0] p, input logic [63:0] pc, input logic m);
    item_t it;
    int s;
    if (ent_mis(pc, m)) begin
      it = '{NOP, pc, 1'b1, 1'b0, 1'b1};
      mq.push_back(it);
    end else begin
      s = (nent == 0) ? int'(pc[2]) : 0;
      for (int w = s; w < 2; w++) begin
        it.instr = p[32*w +: 32];
        it.pc    = {pc[63:3], 3'(w*4)};
        it.mis   = 1'b0;
        it.rvc   = 1'b0;
        it.last  = (w == 1);
        mq.push_back(it);
      end
    end
    nent++;
  endfunction
  task automatic cyc(input logic v, input logic [63:0] p, input logic [63:0] pc,
                     input logic m, input logic st, input logic fl);
    item_t it;
    if_parcel_valid = v; if_parcel = p; if_parcel_pc = pc; if_parcel_misaligned = m;
    id_stall = st; if_flush = fl;
    e_valid = (mq.size() != 0) && !fl;
    e_stall = nent >= DEPTH-1;
    if (mq.size() != 0) e_it = mq[0];
    @(negedge clk);
    o_valid = id_valid; o_stall = if_stall; o_instr = id_instr; o_pc = id_pc;
    o_mis = id_misaligned; o_rvc = id_is_rvc;
    if (o_valid && !st) begin
      it = '{o_instr, o_pc, o_mis, o_rvc, 1'b0};
      got.push_back(it);
    end
    @(posedge clk);
    if (fl) begin
      mq.delete();
      nent = 0;
    end else begin
      if (e_valid && !st) begin
        if (mq[0].last) nent--;
        void'(mq.pop_front());
      end
      if (v && nent < DEPTH) model_push(p, pc, m);
    end
    #1;
  endtask
  task automatic idle(input int n, input logic st);
    repeat (n) cyc(1'b0, '0, '0, 1'b0, st, 1'b0);
  endtask
  task automatic apply_reset();
    rst = 1'b1; if_parcel_valid = 1'b0; if_flush = 1'b0; id_stall = 1'b0; if_parcel_misaligned = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mq.delete(); got.delete(); nent = 0;
  endtask
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_cmp++;
    if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 64'h0 || if_stall !== 1'b0 ||
        id_misaligned !== 1'b0 || id_is_rvc !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: valid=%b instr=%h pc=%h stall=%b mis=%b rvc=%b, required 0 00000013 0 0 0 0",
               id_valid, id_instr, id_pc, if_stall, id_misaligned, id_is_rvc);
    end
    @(posedge clk); #1;
  endtask
  task automatic test_two_parcels();
    logic [63:0] pa, pb;
    logic [63:0] ep [4];
    logic [31:0] ei [4];
    apply_reset();
    pa = {$urandom, $urandom} | 64'h0000_0003_0000_0003;
    pb = {$urandom, $urandom} | 64'h0000_0003_0000_0003;
    ep = '{64'h1000, 64'h1004, 64'h1008, 64'h100C};
    ei = '{pa[31:0], pa[63:32], pb[31:0], pb[63:32]};
    cyc(1'b1, pa, 64'h1000, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, pb, 64'h1008, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    n_cmp++;
    if (got.size() != 4) begin
      n_bad++;
      $display("FAIL two_parcels_count: got %0d items in 4 cycles, required 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i].pc !== ep[i] || got[i].instr !== ei[i] || got[i].mis !== 1'b0) begin
        n_bad++;
        $display("FAIL two_parcels_item%0d: pc=%h instr=%h mis=%b, required pc=%h instr=%h mis=0",
                 i, got[i].pc, got[i].instr, got[i].mis, ep[i], ei[i]);
      end
    end
    idle(1, 1'b0);
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL two_parcels_drained: id_valid=%b, required 0", o_valid);
    end
  endtask
  task automatic test_single_offset();
    logic [63:0] p;
    apply_reset();
    p = {32'h1234_5673, 32'hDEAD_BEEF};
    cyc(1'b1, p, 64'h2004, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    n_cmp++;
    if (o_valid !== 1'b1 || o_pc !== 64'h2004 || o_instr !== 32'h1234_5673) begin
      n_bad++;
      $display("FAIL single_offset: valid=%b pc=%h instr=%h, required 1 2004 12345673", o_valid, o_pc, o_instr);
    end
    idle(1, 1'b0);
    n_cmp++;
    if (o_valid !== 1'b0 || o_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL single_offset_pop: valid=%b stall=%b, required 0 0", o_valid, o_stall);
    end
  endtask
  task automatic test_stall_hold();
    logic [63:0] p [3];
    logic [63:0] ep [6];
    logic [31:0] ei [6];
    apply_reset();
    for (int i = 0; i < 3; i++) p[i] = {$urandom, $urandom} | 64'h0000_0003_0000_0003;
    ep = '{64'h6000, 64'h6004, 64'h6008, 64'h600C, 64'h6010, 64'h6014};
    ei = '{p[0][31:0], p[0][63:32], p[1][31:0], p[1][63:32], p[2][31:0], p[2][63:32]};
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, p[i], 64'h6000 + 64'(8*i), 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (o_stall !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_early%0d: if_stall=%b, required 0", i, o_stall);
      end
    end
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b1);
      n_cmp++;
      if (o_stall !== 1'b1 || o_valid !== 1'b1 || o_instr !== ei[0] || o_pc !== 64'h6000) begin
        n_bad++;
        $display("FAIL stall_hold%0d: stall=%b valid=%b instr=%h pc=%h, required 1 1 %h 6000",
                 i, o_stall, o_valid, o_instr, o_pc, ei[0]);
      end
    end
    idle(7, 1'b0);
    n_cmp++;
    if (got.size() != 6) begin
      n_bad++;
      $display("FAIL stall_drain_count: got %0d, required 6", got.size());
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i].pc !== ep[i] || got[i].instr !== ei[i]) begin
        n_bad++;
        $display("FAIL stall_drain%0d: pc=%h instr=%h, required pc=%h instr=%h",
                 i, got[i].pc, got[i].instr, ep[i], ei[i]);
      end
    end
  endtask
  task automatic test_flush();
    logic [63:0] pd;
    apply_reset();
    pd = {$urandom, $urandom} | 64'h0000_0003_0000_0003;
    cyc(1'b1, 64'h0000_0013_0000_0013, 64'h3100, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 64'h0000_0013_0000_0013, 64'h3108, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 64'h0000_0093_0000_0093, 64'h3200, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_same_cycle: id_valid=%b, required 0", o_valid);
    end
    idle(1, 1'b0);
    n_cmp++;
    if (o_valid !== 1'b0 || o_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_empty: valid=%b stall=%b, required 0 0", o_valid, o_stall);
    end
    got.delete();
    cyc(1'b1, pd, 64'h3000, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    n_cmp++;
    if (got.size() < 1 || got[0].pc !== 64'h3000 || got[0].instr !== pd[31:0]) begin
      n_bad++;
      $display("FAIL flush_next: items=%0d pc=%h instr=%h, required pc=3000 instr=%h",
               got.size(), o_pc, o_instr, pd[31:0]);
    end
  endtask
  task automatic test_misaligned();
    logic [63:0] mpc;
`ifdef RVC_EN
    mpc = 64'h4001;
`else
    mpc = 64'h4002;
`endif
    apply_reset();
    cyc(1'b1, {$urandom, $urandom}, mpc, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    n_cmp++;
    if (o_valid !== 1'b1 || o_mis !== 1'b1 || o_instr !== NOP || o_pc !== mpc || o_rvc !== 1'b0) begin
      n_bad++;
      $display("FAIL misaligned_pc: valid=%b mis=%b instr=%h pc=%h rvc=%b, required 1 1 00000013 %h 0",
               o_valid, o_mis, o_instr, o_pc, o_rvc, mpc);
    end
    idle(1, 1'b0);
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL misaligned_pc_once: id_valid=%b, required 0", o_valid);
    end
    cyc(1'b1, 64'h0000_0013_0000_0013, 64'h4100, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    n_cmp++;
    if (o_valid !== 1'b1 || o_mis !== 1'b1 || o_instr !== NOP || o_pc !== 64'h4100) begin
      n_bad++;
      $display("FAIL misaligned_flag: valid=%b mis=%b instr=%h pc=%h, required 1 1 00000013 4100",
               o_valid, o_mis, o_instr, o_pc);
    end
    idle(1, 1'b0);
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL misaligned_flag_once: id_valid=%b, required 0", o_valid);
    end
  endtask
  task automatic test_back_to_back();
    logic [63:0] pa, pb;
    apply_reset();
    pa = {$urandom, $urandom} | 64'h0000_0003_0000_0003;
    pb = {$urandom, $urandom} | 64'h0000_0003_0000_0003;
    cyc(1'b1, pa, 64'h7004, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, pb, 64'h700C, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    n_cmp++;
    if (got.size() != 2 || got[0].pc !== 64'h7004 || got[0].instr !== pa[63:32] ||
        got[1].pc !== 64'h700C || got[1].instr !== pb[63:32]) begin
      n_bad++;
      $display("FAIL back_to_back: items=%0d last pc=%h instr=%h, required 2 items 7004/%h then 700C/%h",
               got.size(), o_pc, o_instr, pa[63:32], pb[63:32]);
    end
  endtask
  task automatic test_reset_mid();
    apply_reset();
    cyc(1'b1, 64'h0000_0013_0000_0013, 64'h8000, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 64'h0000_0013_0000_0013, 64'h8008, 1'b0, 1'b1, 1'b0);
    if_parcel_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (id_valid !== 1'b0 || if_stall !== 1'b0 || id_pc !== 64'h0 || id_instr !== NOP) begin
      n_bad++;
      $display("FAIL reset_mid: valid=%b stall=%b pc=%h instr=%h, required 0 0 0 00000013",
               id_valid, if_stall, id_pc, id_instr);
    end
    apply_reset();
  endtask
  task automatic test_random();
    logic v, m, st, fl;
    logic [63:0] p, pc;
    logic [2:0] lows [8];
    lows = '{3'h0, 3'h4, 3'h0, 3'h4, 3'h2, 3'h6, 3'h1, 3'h4};
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      v  = (nent < DEPTH-1) && ($urandom_range(2) != 0);
      p  = {$urandom, $urandom};
      pc = {$urandom, $urandom};
      pc[2:0] = lows[$urandom_range(7)];
`ifdef RVC_EN
      p = p | 64'h0000_0003_0000_0003;
      if (!pc[0]) pc[1] = 1'b0;
`endif
      m  = ($urandom_range(9) == 0);
      st = ($urandom_range(3) == 0);
      fl = ($urandom_range(24) == 0);
      cyc(v, p, pc, m, st, fl);
      n_cmp++;
      if (o_valid !== e_valid || o_stall !== e_stall) begin
        n_bad++;
        $display("FAIL random%0d_ctrl: valid=%b stall=%b, required %b %b", i, o_valid, o_stall, e_valid, e_stall);
      end else if (e_valid) begin
        n_cmp++;
        if (o_instr !== e_it.instr || o_pc !== e_it.pc || o_mis !== e_it.mis || o_rvc !== 1'b0) begin
          n_bad++;
          $display("FAIL random%0d_item: instr=%h pc=%h mis=%b rvc=%b, required %h %h %b 0",
                   i, o_instr, o_pc, o_mis, o_rvc, e_it.instr, e_it.pc, e_it.mis);
        end
      end
    end
  endtask
`ifdef RVC_EN
  task automatic test_rvc_seq();
    logic [63:0] ep [7];
    logic [31:0] ei [7];
    logic        er [7];
    apply_reset();
    ep = '{64'h5000, 64'h5002, 64'h5004, 64'h5008, 64'h500A, 64'h500C, 64'h500E};
    ei = '{32'h1, 32'h4501, 32'h113, 32'h1, 32'h1, 32'h1, 32'h1};
    er = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    cyc(1'b1, 64'h0000_0113_4501_0001, 64'h5000, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h0001_0001_0001_0001, 64'h5008, 1'b0, 1'b0, 1'b0);
    idle(6, 1'b0);
    n_cmp++;
    if (got.size() != 7) begin
      n_bad++;
      $display("FAIL rvc_seq_count: got %0d, required 7", got.size());
    end
    for (int i = 0; i < 7 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i].pc !== ep[i] || got[i].instr !== ei[i] || got[i].rvc !== er[i]) begin
        n_bad++;
        $display("FAIL rvc_seq%0d: pc=%h instr=%h rvc=%b, required %h %h %b",
                 i, got[i].pc, got[i].instr, got[i].rvc, ep[i], ei[i], er[i]);
      end
    end
  endtask
  task automatic test_rvc_straddle();
    apply_reset();
    cyc(1'b1, 64'h0093_0000_0000_0000, 64'h5006, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b1, 64'h0001_0001_0001_0000, 64'h5008, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (got.size() != 0 || o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rvc_straddle_wait: items=%0d valid=%b, required 0 0", got.size(), o_valid);
    end
    idle(1, 1'b0);
    n_cmp++;
    if (o_valid !== 1'b1 || o_instr !== 32'h0000_0093 || o_pc !== 64'h5006 || o_rvc !== 1'b0) begin
      n_bad++;
      $display("FAIL rvc_straddle: valid=%b instr=%h pc=%h rvc=%b, required 1 00000093 5006 0",
               o_valid, o_instr, o_pc, o_rvc);
    end
    idle(1, 1'b0);
    n_cmp++;
    if (o_valid !== 1'b1 || o_instr !== 32'h1 || o_pc !== 64'h500A || o_rvc !== 1'b1) begin
      n_bad++;
      $display("FAIL rvc_after_straddle: valid=%b instr=%h pc=%h rvc=%b, required 1 00000001 500a 1",
               o_valid, o_instr, o_pc, o_rvc);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_two_parcels();
    test_single_offset();
    test_stall_hold();
    test_flush();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef RVC_EN
    test_rvc_seq();
    test_rvc_straddle();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
